// File: rtl/wb_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer_if
// Description : Wishbone classic bus bundle between the CPU-side master and
//               the wb_timer slave. Signal names are from the slave's view
//               (_i = into the timer, _o = out of the timer).
//   wb_adr_i  [31:0]  byte address
//   wb_dat_i  [31:0]  write data
//   wb_sel_i  [3:0]   byte lane enables
//   wb_we_i           write enable
//   wb_cyc_i          bus cycle
//   wb_stb_i          strobe
//   wb_dat_o  [31:0]  read data
//   wb_ack_o          transfer acknowledge
//   wb_err_o          error acknowledge
// Revision    : 1.0  initial release
// ============================================================================
interface wb_timer_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_timer.sv
`default_nettype none
// ============================================================================
// Module      : wb_timer
// Description : Wishbone classic slave timer. A prescaled 32-bit up-counter
//               is compared against a COMPARE register; a match sets the
//               sticky MATCH flag, which drives a level interrupt when
//               IRQ_EN is set.
//   wb_clk_i          system clock, rising edge
//   wb_rst_i          asynchronous active-high reset
//   wb  (slave)       Wishbone classic bus (see wb_timer_if)
//   irq_o             level interrupt = MATCH & IRQ_EN
//   Register map (word offset = wb_adr_i[4:2]):
//     0 CTRL      [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
//     1 PRESCALE  [PRESCALE_WIDTH-1:0]
//     2 COUNT
//     3 COMPARE
//     4 STATUS    [0] MATCH, write-1-to-clear
//     5..7        unmapped, answered with wb_err_o
// Revision    : 1.0  initial release
// ============================================================================
module wb_timer #(
  parameter int unsigned PRESCALE_WIDTH = 16,
  parameter logic [31:0] COUNT_RESET    = 32'h0000_0000
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  wb_timer_if.slave      wb,
  output logic           irq_o
);

  localparam logic [2:0] c_off_ctrl     = 3'd0;
  localparam logic [2:0] c_off_prescale = 3'd1;
  localparam logic [2:0] c_off_count    = 3'd2;
  localparam logic [2:0] c_off_compare  = 3'd3;
  localparam logic [2:0] c_off_status   = 3'd4;

  localparam int unsigned c_bit_en     = 0;
  localparam int unsigned c_bit_reload = 1;
  localparam int unsigned c_bit_irq_en = 2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [2:0]                ctrl_q,     ctrl_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pcnt_q,     pcnt_d;
  logic [31:0]               count_q,    count_d;
  logic [31:0]               compare_q,  compare_d;
  logic                      match_q,    match_d;
  logic                      ack_q,      ack_d;
  logic                      err_q,      err_d;
  logic [31:0]               dat_q,      dat_d;

  // --------------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------------
  logic [2:0]  w_off;
  logic        w_req;
  logic        w_mapped;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_prescale;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_w1c;
  logic [31:0] w_rdata;
  logic [31:0] w_wmerge;
  logic        w_unused_adr;

  assign w_off = wb.wb_adr_i[4:2];

  // Only the word offset is decoded; the remaining address bits are ignored.
  assign w_unused_adr = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  // A new transfer is accepted only while no response is being presented,
  // which forces one idle cycle between back-to-back transfers.
  assign w_req    = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q & ~err_q;
  assign w_mapped = (w_off <= c_off_status);
  assign w_wr     = w_req & w_mapped & wb.wb_we_i;

  assign w_wr_ctrl     = w_wr & (w_off == c_off_ctrl);
  assign w_wr_prescale = w_wr & (w_off == c_off_prescale);
  assign w_wr_count    = w_wr & (w_off == c_off_count);
  assign w_wr_compare  = w_wr & (w_off == c_off_compare);
  assign w_w1c         = w_wr & (w_off == c_off_status) & wb.wb_sel_i[0] & wb.wb_dat_i[0];

  // Current contents of the addressed register, zero-padded to 32 bits.
  always_comb begin
    w_rdata = 32'h0000_0000;
    case (w_off)
      c_off_ctrl:     w_rdata = {29'd0, ctrl_q};
      c_off_prescale: w_rdata = 32'(prescale_q);
      c_off_count:    w_rdata = count_q;
      c_off_compare:  w_rdata = compare_q;
      c_off_status:   w_rdata = {31'd0, match_q};
      default:        w_rdata = 32'h0000_0000;
    endcase
  end

  // Byte-lane merge of the write data into the addressed register. Narrow
  // registers take the low bits, so unimplemented bits are simply dropped.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  assign w_wmerge = merge_bytes(w_rdata, wb.wb_dat_i, wb.wb_sel_i);

  // --------------------------------------------------------------------------
  // Prescaler and counter
  // --------------------------------------------------------------------------
  logic w_tick;
  logic w_hit;

  assign w_tick = ctrl_q[c_bit_en] & (pcnt_q == prescale_q);
  // Compared against the pre-edge COMPARE, so a same-cycle COMPARE write
  // only takes effect from the following tick.
  assign w_hit  = (count_q == compare_q);

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_d    = match_q;

    if (w_wr_ctrl)     ctrl_d     = w_wmerge[2:0];
    if (w_wr_prescale) prescale_d = w_wmerge[PRESCALE_WIDTH-1:0];
    if (w_wr_compare)  compare_d  = w_wmerge;

    // Prescale counter: a PRESCALE write restarts the period from zero.
    if (w_wr_prescale) begin
      pcnt_d = '0;
    end else if (ctrl_q[c_bit_en]) begin
      pcnt_d = w_tick ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
    end

    // A bus write to COUNT overrides the tick entirely, including the
    // match check for that tick.
    if (w_wr_count) begin
      count_d = w_wmerge;
    end else if (w_tick) begin
      if (w_hit && ctrl_q[c_bit_reload]) count_d = 32'h0000_0000;
      else                               count_d = count_q + 32'd1;
    end

    // Setting has priority over a same-cycle write-1-to-clear.
    match_d = (w_tick & ~w_wr_count & w_hit) | (match_q & ~w_w1c);
  end

  // --------------------------------------------------------------------------
  // Bus response
  // --------------------------------------------------------------------------
  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = dat_q;
    if (w_req) begin
      ack_d = w_mapped;
      err_d = ~w_mapped;
      dat_d = w_mapped ? w_rdata : 32'h0000_0000;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_q     <= 3'd0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      count_q    <= COUNT_RESET;
      compare_q  <= 32'hFFFF_FFFF;
      match_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= 32'h0000_0000;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_dat_o = dat_q;

  // Built from flops only, so there is no combinational path from the bus.
  assign irq_o = match_q & ctrl_q[c_bit_irq_en];

endmodule
`default_nettype wire

// File: tb/tb_wb_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_timer
// Description : Self-checking bench for wb_timer. A behavioural model tracks
//               the timer in terms of elapsed cycles and whole prescale
//               periods; each bus transfer and idle stretch advances it.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  wb_timer_if bus ();

  wb_timer #(
    .PRESCALE_WIDTH (16),
    .COUNT_RESET    (32'h0000_0000)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [2:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_count;
  logic [31:0] m_cmp;
  logic        m_match;
  longint      m_phase;   // cycles elapsed in the current prescale period

  task automatic model_reset();
    m_ctrl  = 3'd0;
    m_pre   = 32'd0;
    m_count = 32'd0;
    m_cmp   = 32'hFFFF_FFFF;
    m_match = 1'b0;
    m_phase = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_pre;
      3'd2:    return m_count;
      3'd3:    return m_cmp;
      3'd4:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // One counter step: match sets the flag and optionally reloads to zero.
  task automatic model_tick();
    if (m_count == m_cmp) begin
      m_match = 1'b1;
      m_count = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
    end else begin
      m_count = m_count + 32'd1;
    end
  endtask

  // n clock edges with no bus write: a tick ends each full period of PRESCALE+1.
  task automatic model_advance(input int n);
    longint per, tot, nt;
    if (m_ctrl[0]) begin
      per = longint'(m_pre) + 1;
      tot = m_phase + n;
      nt  = tot / per;
      m_phase = tot % per;
      for (longint k = 0; k < nt; k++) model_tick();
    end
  endtask

  // One clock edge carrying a register write.
  task automatic model_write_edge(input logic [2:0] off, input logic [31:0] d,
                                  input logic [3:0] s);
    bit tick;
    logic [31:0] v;
    tick = m_ctrl[0] && (m_phase == longint'(m_pre));
    if (m_ctrl[0]) m_phase = tick ? 0 : m_phase + 1;
    if (off == 3'd4 && s[0] && d[0]) m_match = 1'b0;
    if (tick && off != 3'd2) model_tick();
    v = merge(model_read(off), d, s);
    case (off)
      3'd0: m_ctrl  = v[2:0];
      3'd1: begin m_pre = {16'd0, v[15:0]}; m_phase = 0; end
      3'd2: m_count = v;
      3'd3: m_cmp   = v;
      default: ;
    endcase
  endtask

  // --------------------------------------------------------------------------
  // Bus access (called at posedge+1, returns at posedge+1)
  // --------------------------------------------------------------------------
  task automatic xfer(input string nm, input bit we, input logic [2:0] off,
                      input logic [31:0] data, input logic [3:0] sel,
                      output logic [31:0] rdata);
    logic [31:0] exp_rd, rnd;
    logic        exp_err, exp_irq;
    exp_err = (off > 3'd4);
    exp_rd  = exp_err ? 32'd0 : model_read(off);
    rnd = $urandom();
    bus.wb_adr_i = {rnd[31:5], off, rnd[1:0]};
    bus.wb_dat_i = data;
    bus.wb_sel_i = sel;
    bus.wb_we_i  = we;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk);
    if (we && !exp_err) model_write_edge(off, data, sel);
    else                model_advance(1);
    #1;
    n_checks++;
    if (bus.wb_ack_o !== !exp_err || bus.wb_err_o !== exp_err) begin
      n_errors++;
      $display("FAIL %s resp: ack=%b err=%b required ack=%b err=%b",
               nm, bus.wb_ack_o, bus.wb_err_o, !exp_err, exp_err);
    end
    if (!we || exp_err) begin
      n_checks++;
      if (bus.wb_dat_o !== exp_rd) begin
        n_errors++;
        $display("FAIL %s data: got %h required %h", nm, bus.wb_dat_o, exp_rd);
      end
    end
    rdata = bus.wb_dat_o;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk);
    model_advance(1);
    #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL %s release: ack=%b err=%b required 0 0", nm, bus.wb_ack_o, bus.wb_err_o);
    end
    exp_irq = m_match & m_ctrl[2];
    n_checks++;
    if (irq !== exp_irq) begin
      n_errors++;
      $display("FAIL %s irq: got %b required %b", nm, irq, exp_irq);
    end
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    xfer("write", 1'b1, off, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    xfer("read", 1'b0, off, 32'd0, 4'hF, d);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      model_advance(n);
      #1;
    end
  endtask

  // --------------------------------------------------------------------------
  // Tests
  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_rst [5];
    exp_rst = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_dat_o !== 32'd0 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL reset outputs: ack=%b err=%b dat=%h irq=%b required all 0",
               bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, irq);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), v);
      n_checks++;
      if (v !== exp_rst[i]) begin
        n_errors++;
        $display("FAIL reset reg%0d: got %h required %h", i, v, exp_rst[i]);
      end
    end
  endtask

  task automatic test_prescale();
    logic [31:0] r1, r2, v;
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd3);
    wr(3'd3, 32'd5);
    wr(3'd4, 32'd1);
    wr(3'd0, 32'd7);
    rd(3'd2, r1);
    idle(2);
    rd(3'd2, r2);
    n_checks++;
    if (!((r2 == r1 + 32'd1) || (r1 == 32'd5 && r2 == 32'd0))) begin
      n_errors++;
      $display("FAIL prescale step: first %h then %h required one increment", r1, r2);
    end
    for (int i = 0; i < 8; i++) begin
      rd(3'd2, v);
      n_checks++;
      if (v > 32'd5) begin
        n_errors++;
        $display("FAIL prescale reload: count %h required <= 5", v);
      end
      idle(i % 3);
    end
    idle(30);
    rd(3'd4, v);
    n_checks++;
    if (v !== 32'd1 || irq !== 1'b1) begin
      n_errors++;
      $display("FAIL prescale match: status=%h irq=%b required 1 1", v, irq);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    wr(3'd0, 32'd0);
    wr(3'd4, 32'd1);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd0, 32'd5);
    rd(3'd2, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL wrap count: got %h required ffffffff", v);
    end
    rd(3'd4, v);
    n_checks++;
    if (v !== 32'd1) begin
      n_errors++;
      $display("FAIL wrap match: got %h required 1", v);
    end
    rd(3'd2, v);
    n_checks++;
    if (v !== 32'd3) begin
      n_errors++;
      $display("FAIL wrap post count: got %h required 3", v);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] v, dummy;
    wr(3'd0, 32'd0);
    wr(3'd3, 32'hFFFF_FFFF);
    xfer("bytewr", 1'b1, 3'd3, 32'h0000_AB00, 4'b0010, dummy);
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'hFFFF_ABFF) begin
      n_errors++;
      $display("FAIL byte write: got %h required ffffabff", v);
    end
    xfer("prewr", 1'b1, 3'd1, 32'hDEAD_BEEF, 4'b1111, dummy);
    rd(3'd1, v);
    n_checks++;
    if (v !== 32'h0000_BEEF) begin
      n_errors++;
      $display("FAIL prescale width: got %h required 0000beef", v);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] v;
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd7);   // compare 0 + reload: a match on every cycle
    wr(3'd4, 32'd1);
    rd(3'd4, v);
    n_checks++;
    if (v !== 32'd1 || irq !== 1'b1) begin
      n_errors++;
      $display("FAIL w1c race: status=%h irq=%b required 1 1", v, irq);
    end
    wr(3'd0, 32'd4);
    wr(3'd4, 32'd1);
    rd(3'd4, v);
    n_checks++;
    if (v !== 32'd0 || irq !== 1'b0) begin
      n_errors++;
      $display("FAIL w1c clear: status=%h irq=%b required 0 0", v, irq);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] snap [5];
    logic [31:0] v, dummy;
    wr(3'd0, 32'd6);
    for (int i = 0; i < 5; i++) snap[i] = model_read(3'(i));
    xfer("unmapped6", 1'b1, 3'd6, $urandom(), 4'hF, dummy);
    xfer("unmapped5", 1'b0, 3'd5, 32'd0, 4'hF, dummy);
    xfer("unmapped7", 1'b1, 3'd7, $urandom(), 4'hF, dummy);
    for (int i = 0; i < 5; i++) begin
      rd(3'(i), v);
      n_checks++;
      if (v !== snap[i]) begin
        n_errors++;
        $display("FAIL unmapped side effect reg%0d: got %h required %h", i, v, snap[i]);
      end
    end
  endtask

  task automatic test_no_cyc();
    logic [31:0] v;
    bus.wb_adr_i = 32'h8;
    bus.wb_dat_i = 32'h1234_5678;
    bus.wb_sel_i = 4'hF;
    bus.wb_we_i  = 1'b1;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      model_advance(1);
      #1;
      n_checks++;
      if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
        n_errors++;
        $display("FAIL no-cyc resp: ack=%b err=%b required 0 0", bus.wb_ack_o, bus.wb_err_o);
      end
    end
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    rd(3'd2, v);
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bus.wb_adr_i = 32'h0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset pre: ack=%b required 1", bus.wb_ack_o);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset async: ack=%b err=%b required 0 0", bus.wb_ack_o, bus.wb_err_o);
    end
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    rd(3'd3, v);
    n_checks++;
    if (v !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL midreset compare: got %h required ffffffff", v);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, dummy;
    logic [2:0]  off;
    logic [3:0]  sel;
    for (int i = 0; i < 80; i++) begin
      off = 3'($urandom_range(0, 7));
      sel = 4'($urandom_range(0, 15));
      d   = $urandom();
      if (off == 3'd1) d = 32'($urandom_range(0, 3));
      else if ((off == 3'd2 || off == 3'd3) && $urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 12));
      if (off == 3'd1 || off == 3'd2 || off == 3'd3) sel = 4'hF;
      xfer("random", $urandom_range(0, 1) == 1, off, d, sel, dummy);
      idle($urandom_range(0, 4));
    end
    for (int i = 0; i < 5; i++) xfer("random final", 1'b0, 3'(i), 32'd0, 4'hF, dummy);
  endtask

  // --------------------------------------------------------------------------
  initial begin
    bus.wb_adr_i = 32'd0;
    bus.wb_dat_i = 32'd0;
    bus.wb_sel_i = 4'd0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_prescale();
    test_wrap();
    test_byte_write();
    test_w1c_race();
    test_unmapped();
    test_no_cyc();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
